// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM march-test controller: FSM states, default RAM geometry
// and the error counter width.
package ram_bist_pkg;

    localparam int ADDRESS_WIDTH_0301 = 4;
    localparam int DATA_WIDTH_0301    = 8;
    localparam int ERR_CNT_W          = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_BG   = 3'd1,
        RD_WR  = 3'd2,
        RD_INV = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-compare pipeline: carries {valid, addr, expected} for RD_LATENCY cycles, then checks
// the RAM read-back against the expected word.
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDRESS_WIDTH_0301,
    parameter int DATA_WIDTH = DATA_WIDTH_0301,
    parameter int RD_LATENCY = 1
)(
    input  logic                  clk,
    input  logic                  sync_rst_n,
    input  logic                  i_push,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_expected,
    input  logic [DATA_WIDTH-1:0] i_q,
    output logic                  o_mismatch,
    output logic [ADDR_WIDTH-1:0] o_mismatch_addr,
    output logic [DATA_WIDTH-1:0] o_mismatch_data,
    output logic                  o_busy
);

    logic [RD_LATENCY-1:0]                 r_valid;
    logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] r_addr;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] r_exp;

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            r_valid <= '0;
            r_addr  <= '0;
            r_exp   <= '0;
        end else begin
            r_valid[0] <= i_push;
            r_addr[0]  <= i_addr;
            r_exp[0]   <= i_expected;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_addr[i]  <= r_addr[i-1];
                r_exp[i]   <= r_exp[i-1];
            end
        end
    end

    // The last stage lines up with the cycle in which the RAM presents that read's data.
    assign o_mismatch      = r_valid[RD_LATENCY-1] && (i_q != r_exp[RD_LATENCY-1]);
    assign o_mismatch_addr = r_addr[RD_LATENCY-1];
    assign o_mismatch_data = i_q;
    assign o_busy          = |r_valid;

endmodule

// File: rtl/ram_bist_ctrl.sv
// March test controller (write BG up; read BG/write ~BG up; read ~BG down) for a single-port RAM.
// Define BIST_ERR_LOG_EN to build the first-failure capture and saturating error counter.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDRESS_WIDTH_0301,
    parameter int                    DATA_WIDTH = DATA_WIDTH_0301,
    parameter int                    DEPTH      = 2**ADDR_WIDTH,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] BACKGROUND = {DATA_WIDTH/2{2'b01}}
)(
    input  logic                  clk,
    input  logic                  sync_rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  mem_clken,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state, w_nextState;
    logic [ADDR_WIDTH-1:0] r_addr, w_nextAddr;
    logic                  r_phase, w_nextPhase;
    logic                  r_fail, r_pass;
    logic                  w_startOk, w_memClken, w_memWe;
    logic [DATA_WIDTH-1:0] w_memData, w_expected;
    logic                  w_mismatch, w_cmpBusy;
    logic [ADDR_WIDTH-1:0] w_misAddr;
    logic [DATA_WIDTH-1:0] w_misData;

    assign w_startOk = start && ((r_state == IDLE) || (r_state == DONE));

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_addr  <= w_nextAddr;
            r_phase <= w_nextPhase;
        end
    end

    // r_phase splits each RD_WR word into its read cycle (0) and write cycle (1).
    always_comb begin
        w_nextState = r_state;
        w_nextAddr  = r_addr;
        w_nextPhase = r_phase;
        w_memClken  = 1'b0;
        w_memWe     = 1'b0;
        w_memData   = '0;
        w_expected  = '0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_nextState = W_BG;
                    w_nextAddr  = '0;
                    w_nextPhase = 1'b0;
                end
            end
            W_BG: begin
                w_memClken = 1'b1;
                w_memWe    = 1'b1;
                w_memData  = BACKGROUND;
                if (r_addr == LAST_ADDR) begin
                    w_nextState = RD_WR;
                    w_nextAddr  = '0;
                end else begin
                    w_nextAddr = r_addr + ADDR_WIDTH'(1);
                end
            end
            RD_WR: begin
                w_memClken  = 1'b1;
                w_expected  = BACKGROUND;
                w_nextPhase = !r_phase;
                if (r_phase) begin
                    w_memWe   = 1'b1;
                    w_memData = ~BACKGROUND;
                    if (r_addr == LAST_ADDR) begin
                        w_nextState = RD_INV;
                    end else begin
                        w_nextAddr = r_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            RD_INV: begin
                w_memClken = 1'b1;
                w_expected = ~BACKGROUND;
                if (r_addr == '0) begin
                    w_nextState = DRAIN;
                end else begin
                    w_nextAddr = r_addr - ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (!w_cmpBusy) begin
                    w_nextState = DONE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    ram_bist_cmp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_cmp (
        .clk             (clk),
        .sync_rst_n      (sync_rst_n),
        .i_push          (w_memClken && !w_memWe),
        .i_addr          (r_addr),
        .i_expected      (w_expected),
        .i_q             (mem_q),
        .o_mismatch      (w_mismatch),
        .o_mismatch_addr (w_misAddr),
        .o_mismatch_data (w_misData),
        .o_busy          (w_cmpBusy)
    );

    always_ff @(posedge clk) begin
        if (!sync_rst_n || w_startOk) begin
            r_fail <= 1'b0;
            r_pass <= 1'b0;
        end else begin
            if (w_mismatch) begin
                r_fail <= 1'b1;
            end
            if ((r_state == DRAIN) && (w_nextState == DONE)) begin
                r_pass <= !r_fail;
            end
        end
    end

`ifdef BIST_ERR_LOG_EN
    logic [ADDR_WIDTH-1:0] r_failAddr;
    logic [DATA_WIDTH-1:0] r_failData;
    logic [ERR_CNT_W-1:0]  r_errCnt;

    // r_fail is still clear on the first mismatch, so only that one is captured.
    always_ff @(posedge clk) begin
        if (!sync_rst_n || w_startOk) begin
            r_failAddr <= '0;
            r_failData <= '0;
            r_errCnt   <= '0;
        end else if (w_mismatch) begin
            if (!r_fail) begin
                r_failAddr <= w_misAddr;
                r_failData <= w_misData;
            end
            if (r_errCnt != '1) begin
                r_errCnt <= r_errCnt + ERR_CNT_W'(1);
            end
        end
    end

    assign fail_addr = r_failAddr;
    assign fail_data = r_failData;
    assign err_cnt   = r_errCnt;
`else
    logic w_unusedDiag;
    assign w_unusedDiag = ^{w_misAddr, w_misData};
    assign fail_addr    = '0;
    assign fail_data    = '0;
    assign err_cnt      = '0;
`endif

    assign busy      = (r_state != IDLE) && (r_state != DONE);
    assign done      = (r_state == DONE);
    assign pass      = r_pass;
    assign mem_addr  = r_addr;
    assign mem_data  = w_memData;
    assign mem_we    = w_memWe;
    assign mem_clken = w_memClken;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl: two DUTs (RD_LATENCY 1 and 2) driving behavioural RAMs,
// with a stuck-at fault injectable into the latency-1 RAM.
module tb_ram_bist_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
`ifdef BIST_ERR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    typedef struct {
        int          doneCyc;
        bit          pass;
        logic [3:0]  fAddr;
        logic [7:0]  fData;
        logic [15:0] errCnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          syncRstN, startA, startB;
    logic          busyA, doneA, passA, weA, clkenA;
    logic [AW-1:0] addrA, failAddrA;
    logic [DW-1:0] dataA, ramQA, failDataA;
    logic [15:0]   errCntA;
    logic          busyB, doneB, passB, weB, clkenB;
    logic [AW-1:0] addrB, failAddrB;
    logic [DW-1:0] dataB, ramQB1, ramQB2, failDataB;
    logic [15:0]   errCntB;

    logic [DW-1:0] memA [DEPTH];
    logic [DW-1:0] memB [DEPTH];
    bit            faultOn = 1'b0;
    int            cyc = 0;
    int            compared = 0;
    int            mismatched = 0;
    bit            prevDoneA = 1'b0;
    bit            prevDoneB = 1'b0;
    exp_t          expQA[$];
    exp_t          expQB[$];

    ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(1)) dutA (
        .clk(clk), .sync_rst_n(syncRstN), .start(startA), .busy(busyA), .done(doneA),
        .pass(passA), .mem_addr(addrA), .mem_data(dataA), .mem_we(weA), .mem_clken(clkenA),
        .mem_q(ramQA), .fail_addr(failAddrA), .fail_data(failDataA), .err_cnt(errCntA)
    );

    ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(2)) dutB (
        .clk(clk), .sync_rst_n(syncRstN), .start(startB), .busy(busyB), .done(doneB),
        .pass(passB), .mem_addr(addrB), .mem_data(dataB), .mem_we(weB), .mem_clken(clkenB),
        .mem_q(ramQB2), .fail_addr(failAddrB), .fail_data(failDataB), .err_cnt(errCntB)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Bit 3 of address 5 is stuck at 0 while faultOn is set.
    always @(posedge clk) begin
        if (clkenA) begin
            if (weA) memA[addrA] <= (faultOn && addrA == 4'd5) ? (dataA & 8'hF7) : dataA;
            else     ramQA <= memA[addrA];
        end
    end

    always @(posedge clk) begin
        ramQB2 <= ramQB1;
        if (clkenB) begin
            if (weB) memB[addrB] <= dataB;
            else     ramQB1 <= memB[addrB];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (doneA && !prevDoneA) begin
            if (expQA.size() == 0) begin
                checkOutput("A unexpected done", 32'd1, 32'd0);
            end else begin
                e = expQA.pop_front();
                checkOutput("A done cycle", cyc, e.doneCyc);
                checkOutput("A pass", {31'd0, passA}, {31'd0, e.pass});
                checkOutput("A busy at done", {31'd0, busyA}, 32'd0);
                checkOutput("A fail_addr", {28'd0, failAddrA}, {28'd0, e.fAddr});
                checkOutput("A fail_data", {24'd0, failDataA}, {24'd0, e.fData});
                checkOutput("A err_cnt", {16'd0, errCntA}, {16'd0, e.errCnt});
            end
        end
        prevDoneA = doneA;
    end

    always @(negedge clk) begin
        exp_t e;
        if (doneB && !prevDoneB) begin
            if (expQB.size() == 0) begin
                checkOutput("B unexpected done", 32'd1, 32'd0);
            end else begin
                e = expQB.pop_front();
                checkOutput("B done cycle", cyc, e.doneCyc);
                checkOutput("B pass", {31'd0, passB}, {31'd0, e.pass});
                checkOutput("B busy at done", {31'd0, busyB}, 32'd0);
            end
        end
        prevDoneB = doneB;
    end

    // Pulses start so the following posedge is edge 0; done is expected after edge 4*DEPTH+L+1.
    task automatic applyStimulus(input bit withB, input bit expectDone, input bit expPass,
                                 input logic [3:0] fa, input logic [7:0] fd, input logic [15:0] ec);
        exp_t e;
        @(negedge clk);
        if (expectDone) begin
            e.doneCyc = cyc + 4*DEPTH + 1 + 2;
            e.pass    = expPass;
            e.fAddr   = LOG_EN ? fa : 4'd0;
            e.fData   = LOG_EN ? fd : 8'd0;
            e.errCnt  = LOG_EN ? ec : 16'd0;
            expQA.push_back(e);
        end
        if (withB) begin
            e.doneCyc = cyc + 4*DEPTH + 2 + 2;
            e.pass    = 1'b1;
            e.fAddr   = 4'd0;
            e.fData   = 8'd0;
            e.errCnt  = 16'd0;
            expQB.push_back(e);
            startB = 1'b1;
        end
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
        checkOutput("busy after edge 0", {31'd0, busyA}, 32'd1);
    endtask

    task automatic waitDone();
        for (int i = 0; i < 200 && (expQA.size() != 0 || expQB.size() != 0); i++) @(negedge clk);
        if (expQA.size() != 0 || expQB.size() != 0) begin
            checkOutput("done timeout", expQA.size() + expQB.size(), 32'd0);
            expQA.delete();
            expQB.delete();
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " busy"},      {31'd0, busyA},     32'd0);
        checkOutput({tag, " done"},      {31'd0, doneA},     32'd0);
        checkOutput({tag, " pass"},      {31'd0, passA},     32'd0);
        checkOutput({tag, " clken"},     {31'd0, clkenA},    32'd0);
        checkOutput({tag, " we"},        {31'd0, weA},       32'd0);
        checkOutput({tag, " addr"},      {28'd0, addrA},     32'd0);
        checkOutput({tag, " data"},      {24'd0, dataA},     32'd0);
        checkOutput({tag, " fail_addr"}, {28'd0, failAddrA}, 32'd0);
        checkOutput({tag, " fail_data"}, {24'd0, failDataA}, 32'd0);
        checkOutput({tag, " err_cnt"},   {16'd0, errCntA},   32'd0);
        checkOutput({tag, " B done"},    {31'd0, doneB},     32'd0);
    endtask

    initial begin
        syncRstN = 1'b0;
        startA   = 1'b0;
        startB   = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        syncRstN = 1'b1;

        $display("[TB] fault-free run, latency 1 and 2");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 16'd0);
        waitDone();

        $display("[TB] stuck-at-0 bit 3 at address 5");
        faultOn = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, 8'hA2, 16'd1);
        waitDone();
        faultOn = 1'b0;

        $display("[TB] restart from DONE after failing run");
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 16'd0);
        checkOutput("done cleared at edge 0", {31'd0, doneA}, 32'd0);
        checkOutput("pass cleared at edge 0", {31'd0, passA}, 32'd0);
        checkOutput("err_cnt cleared at edge 0", {16'd0, errCntA}, 32'd0);
        checkOutput("fail_addr cleared at edge 0", {28'd0, failAddrA}, 32'd0);
        waitDone();

        $display("[TB] start re-pulsed at edge 10");
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 16'd0);
        repeat (9) @(negedge clk);
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        waitDone();

        $display("[TB] reset at edge 30, then full run");
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 16'd0);
        repeat (29) @(negedge clk);
        checkOutput("busy before abort", {31'd0, busyA}, 32'd1);
        syncRstN = 1'b0;
        @(negedge clk);
        checkResetState("abort");
        syncRstN = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 16'd0);
        waitDone();

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
